// File: rtl/mlp_sequencer.sv
// rtl/mlp_sequencer.sv - two-layer MLP inference sequencer with per-row argmax result handshake
module mlp_sequencer #(
    parameter int N_ROW = 10,
    parameter int N_IN  = 50,
    parameter int N_HID = 20,
    parameter int N_OUT = 10,
    parameter int ACC_W = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic [8:0]         img_addr,
    input  logic [9:0]         img_data,
    output logic [9:0]         w1_addr,
    input  logic signed [15:0] w1_data,
    output logic [4:0]         b1_addr,
    input  logic signed [15:0] b1_data,
    output logic [7:0]         w2_addr,
    input  logic signed [15:0] w2_data,
    output logic [3:0]         b2_addr,
    input  logic signed [15:0] b2_data,
    output logic               class_valid,
    input  logic               class_ready,
    output logic [3:0]         class_idx,
    output logic [3:0]         class_row,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, L1, L2, EMIT} state_t;

    localparam logic signed [ACC_W-1:0] RELU_MAX = ACC_W'(65535);

    state_t                  state;
    logic [3:0]              row;
    logic [4:0]              idx;
    logic [5:0]              cyc;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] best;
    logic [3:0]              best_idx;
    logic [15:0]             hidden [N_HID];

    logic [4:0]              h_sel;
    logic signed [26:0]      prod1;
    logic signed [32:0]      prod2;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic [15:0]             relu;
    logic                    take_best;

    // Data for the element issued in cycle cyc-1 arrives in cycle cyc; cycle 1 folds in the bias.
    always_comb begin
        h_sel = (cyc == 6'd0) ? 5'd0 : 5'(cyc - 6'd1);
        prod1 = $signed({1'b0, img_data}) * w1_data;
        prod2 = $signed({1'b0, hidden[h_sel]}) * w2_data;
        if (state == L2) begin
            term = ACC_W'(prod2);
            base = (cyc == 6'd1) ? ACC_W'(b2_data) : acc;
        end else begin
            term = ACC_W'(prod1);
            base = (cyc == 6'd1) ? ACC_W'(b1_data) : acc;
        end
        sum = base + term;
        if (sum[ACC_W-1] || sum == '0) begin
            relu = 16'd0;
        end else if (sum > RELU_MAX) begin
            relu = 16'hFFFF;
        end else begin
            relu = sum[15:0];
        end
        take_best = (idx == 5'd0) || (sum > best);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= 4'd0;
            idx         <= 5'd0;
            cyc         <= 6'd0;
            acc         <= '0;
            best        <= '0;
            best_idx    <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            class_valid <= 1'b0;
            class_idx   <= 4'd0;
            class_row   <= 4'd0;
            img_addr    <= 9'd0;
            w1_addr     <= 10'd0;
            b1_addr     <= 5'd0;
            w2_addr     <= 8'd0;
            b2_addr     <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= L1;
                        busy     <= 1'b1;
                        row      <= 4'd0;
                        idx      <= 5'd0;
                        cyc      <= 6'd0;
                        img_addr <= 9'd0;
                        w1_addr  <= 10'd0;
                        b1_addr  <= 5'd0;
                    end
                end
                L1: begin
                    if (cyc != 6'd0) acc <= sum;
                    if (cyc == 6'(N_IN)) begin
                        hidden[idx] <= relu;
                        cyc         <= 6'd0;
                        if (idx == 5'(N_HID - 1)) begin
                            state   <= L2;
                            idx     <= 5'd0;
                            w2_addr <= 8'd0;
                            b2_addr <= 4'd0;
                        end else begin
                            idx      <= idx + 5'd1;
                            img_addr <= 9'(row * N_IN);
                            w1_addr  <= 10'((idx + 5'd1) * N_IN);
                            b1_addr  <= idx + 5'd1;
                        end
                    end else begin
                        cyc <= cyc + 6'd1;
                        if (cyc == 6'(N_IN - 1)) begin
                            img_addr <= 9'd0;
                            w1_addr  <= 10'd0;
                            b1_addr  <= 5'd0;
                        end else begin
                            img_addr <= img_addr + 9'd1;
                            w1_addr  <= w1_addr + 10'd1;
                        end
                    end
                end
                L2: begin
                    if (cyc != 6'd0) acc <= sum;
                    if (cyc == 6'(N_HID)) begin
                        cyc <= 6'd0;
                        if (take_best) begin
                            best     <= sum;
                            best_idx <= 4'(idx);
                        end
                        if (idx == 5'(N_OUT - 1)) begin
                            state       <= EMIT;
                            class_valid <= 1'b1;
                            class_idx   <= take_best ? 4'(idx) : best_idx;
                            class_row   <= row;
                        end else begin
                            idx     <= idx + 5'd1;
                            w2_addr <= 8'((idx + 5'd1) * N_HID);
                            b2_addr <= 4'(idx + 5'd1);
                        end
                    end else begin
                        cyc <= cyc + 6'd1;
                        if (cyc == 6'(N_HID - 1)) begin
                            w2_addr <= 8'd0;
                            b2_addr <= 4'd0;
                        end else begin
                            w2_addr <= w2_addr + 8'd1;
                        end
                    end
                end
                EMIT: begin
                    if (class_ready) begin
                        class_valid <= 1'b0;
                        if (row == 4'(N_ROW - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            row   <= 4'd0;
                        end else begin
                            state    <= L1;
                            row      <= row + 4'd1;
                            idx      <= 5'd0;
                            cyc      <= 6'd0;
                            img_addr <= 9'((row + 4'd1) * N_IN);
                            w1_addr  <= 10'd0;
                            b1_addr  <= 5'd0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mlp_sequencer.sv
// tb/tb_mlp_sequencer.sv - randomized self-checking bench for mlp_sequencer against a row-level reference model
module tb_mlp_sequencer;
    logic               clk = 1'b0;
    logic               rst_n, start, busy, class_valid, class_ready, done;
    logic [8:0]         img_addr;
    logic [9:0]         img_data, w1_addr;
    logic [4:0]         b1_addr;
    logic [7:0]         w2_addr;
    logic [3:0]         b2_addr, class_idx, class_row;
    logic signed [15:0] w1_data, b1_data, w2_data, b2_data;

    logic [9:0]         img_mem [512];
    logic signed [15:0] w1_mem [1024];
    logic signed [15:0] b1_mem [32];
    logic signed [15:0] w2_mem [256];
    logic signed [15:0] b2_mem [16];

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int hs_q[$];

    bit m_active = 0, m_emit = 0, m_done = 0;
    int m_row = 0, m_count = 0, m_class = 0;

    always #5 clk = ~clk;

    mlp_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
        .img_addr(img_addr), .img_data(img_data),
        .w1_addr(w1_addr), .w1_data(w1_data), .b1_addr(b1_addr), .b1_data(b1_data),
        .w2_addr(w2_addr), .w2_data(w2_data), .b2_addr(b2_addr), .b2_data(b2_data),
        .class_valid(class_valid), .class_ready(class_ready),
        .class_idx(class_idx), .class_row(class_row), .done(done)
    );

    always @(posedge clk) begin
        img_data <= img_mem[img_addr];
        w1_data  <= w1_mem[w1_addr];
        b1_data  <= b1_mem[b1_addr];
        w2_data  <= w2_mem[w2_addr];
        b2_data  <= b2_mem[b2_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic longint ref_hidden(int r, int j);
        longint s = longint'(b1_mem[j]);
        for (int k = 0; k < 50; k++)
            s += longint'(img_mem[r*50+k]) * longint'(w1_mem[j*50+k]);
        if (s <= 0) return 0;
        if (s > 65535) return 65535;
        return s;
    endfunction

    function automatic int ref_class(int r);
        longint h[20];
        longint s, best_s;
        int best;
        best_s = 0;
        best = 0;
        for (int j = 0; j < 20; j++) h[j] = ref_hidden(r, j);
        for (int o = 0; o < 10; o++) begin
            s = longint'(b2_mem[o]);
            for (int j = 0; j < 20; j++) s += h[j] * longint'(w2_mem[o*20+j]);
            if (o == 0 || s > best_s) begin
                best_s = s;
                best = o;
            end
        end
        return best;
    endfunction

    // Row-level timeline: 1230 compute cycles per row, then wait for the result handshake.
    always @(posedge clk) begin
        m_done = 0;
        if (!rst_n) begin
            m_active = 0;
            m_emit = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1;
                m_row = 0;
                m_count = 0;
                m_emit = 0;
            end
        end else if (!m_emit) begin
            m_count++;
            if (m_count == 1230) begin
                m_emit = 1;
                m_class = ref_class(m_row);
            end
        end else if (class_ready) begin
            m_emit = 0;
            if (m_row == 9) begin
                m_active = 0;
                m_done = 1;
            end else begin
                m_row++;
                m_count = 0;
            end
        end
    end

    function automatic logic [46:0] model_outputs();
        int img = 0, w1 = 0, b1 = 0, w2 = 0, b2 = 0;
        if (m_active && !m_emit) begin
            if (m_count < 1020) begin
                int j = m_count / 51;
                int k = m_count % 51;
                if (k < 50) begin
                    img = m_row*50 + k;
                    w1 = j*50 + k;
                    b1 = j;
                end
            end else begin
                int o = (m_count - 1020) / 21;
                int j = (m_count - 1020) % 21;
                if (j < 20) begin
                    w2 = o*20 + j;
                    b2 = o;
                end
            end
        end
        return {m_active, m_done, m_emit, m_emit ? 4'(m_class) : 4'd0, m_emit ? 4'(m_row) : 4'd0,
                9'(img), 10'(w1), 5'(b1), 8'(w2), 4'(b2)};
    endfunction

    function automatic logic [46:0] dut_outputs();
        return {busy, done, class_valid, class_valid ? class_idx : 4'd0, class_valid ? class_row : 4'd0,
                img_addr, w1_addr, b1_addr, w2_addr, b2_addr};
    endfunction

    function automatic logic [46:0] raw_outputs();
        return {busy, done, class_valid, class_idx, class_row, img_addr, w1_addr, b1_addr, w2_addr, b2_addr};
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("cycle_outputs", 64'(dut_outputs()), 64'(model_outputs()));
            if (class_valid && class_ready) hs_q.push_back(int'(class_row)*16 + int'(class_idx));
        end
    end

    task automatic do_run(input int mode, input int stop_after, output int lat, output bit got_done);
        int n = 0, em = 0;
        bit stopped = 0;
        lat = -1;
        got_done = 0;
        hs_q.delete();
        start = 1;
        @(posedge clk); #1;
        start = 0;
        while (1) begin
            case (mode)
                1: begin class_ready = (em >= 100); start = (n == 1100) || (em == 50); end
                2: begin class_ready = ($urandom % 3) != 0; start = ($urandom % 40) == 0; end
                default: begin class_ready = 1; start = 0; end
            endcase
            @(negedge clk);
            n++;
            if (class_valid) begin
                if (lat < 0) lat = n;
                em++;
            end
            if (done) begin got_done = 1; break; end
            if (stop_after < 10 && hs_q.size() >= stop_after) begin stopped = 1; break; end
            if (mode == 3 && m_active && !m_emit && m_row == 2 && m_count == 499) begin stopped = 1; break; end
            if (n >= 20000) begin
                n_checks++;
                n_fail++;
                $display("FAIL run_timeout: actual %0d cycles required done", n);
                break;
            end
            @(posedge clk); #1;
        end
        start = 0;
        class_ready = 0;
        @(posedge clk); #1;
        if (stopped) begin
            rst_n = 0;
            @(posedge clk); #1;
            rst_n = 1;
            @(negedge clk);
            check("abort_reset_outputs", 64'(raw_outputs()), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic fill(input int img_mode, input int w1v, input int b1v, input int w2_mode, input int b2v);
        for (int i = 0; i < 512; i++) img_mem[i] = (img_mode == 0) ? 10'($urandom % 1024) : 10'd1023;
        for (int i = 0; i < 1024; i++) w1_mem[i] = 16'(w1v);
        for (int i = 0; i < 32; i++) b1_mem[i] = (b1v == 9999) ? 16'($urandom) : 16'(b1v);
        for (int i = 0; i < 256; i++) w2_mem[i] = (w2_mode == 1 && i / 20 == 8) ? 16'sd100 : 16'sd0;
        for (int i = 0; i < 16; i++) b2_mem[i] = 16'(b2v);
    endtask

    initial begin
        int lat;
        bit gd;
        rst_n = 0;
        start = 0;
        class_ready = 0;
        fill(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk_en = 1;
        @(negedge clk);
        check("reset_outputs", 64'(raw_outputs()), 64'd0);
        @(posedge clk); #1;

        // Only b2[3] nonzero: every row classifies as 3.
        fill(0, 0, 9999, 0, 0);
        b2_mem[3] = 16'sd5;
        check("model_b2_peak", 64'(ref_class(0)), 64'd3);
        do_run(0, 10, lat, gd);
        check("first_valid_latency", 64'(lat), 64'd1231);
        check("peak_done", 64'(gd), 64'd1);
        check("peak_result_count", 64'(hs_q.size()), 64'd10);
        foreach (hs_q[i]) check("peak_result", 64'(hs_q[i]), 64'(i*16 + 3));

        // All scores tie at 7: lowest index wins; random stalls and stray start pulses.
        fill(0, 0, 9999, 0, 7);
        check("model_tie", 64'(ref_class(5)), 64'd0);
        do_run(2, 10, lat, gd);
        check("tie_result_count", 64'(hs_q.size()), 64'd10);
        foreach (hs_q[i]) check("tie_result", 64'(hs_q[i]), 64'(i*16));

        // Negative pre-activation clamps to 0.
        fill(1, -1, 0, 1, 0);
        check("model_relu_neg", 64'(ref_hidden(0, 0)), 64'd0);
        do_run(0, 2, lat, gd);
        check("relu_neg_count", 64'(hs_q.size()), 64'd2);
        foreach (hs_q[i]) check("relu_neg_result", 64'(hs_q[i]), 64'(i*16));

        fill(1, -1, 1000, 1, 0);
        check("model_relu_bias", 64'(ref_hidden(0, 7)), 64'd0);
        do_run(0, 2, lat, gd);
        foreach (hs_q[i]) check("relu_bias_result", 64'(hs_q[i]), 64'(i*16));

        // Positive activation 51150 reaches class 8; the first result is held 100 cycles.
        fill(1, 1, 0, 1, 0);
        check("model_hidden_pos", 64'(ref_hidden(0, 0)), 64'd51150);
        check("model_class8", 64'(ref_class(9)), 64'd8);
        do_run(1, 10, lat, gd);
        check("held_done", 64'(gd), 64'd1);
        check("held_result_count", 64'(hs_q.size()), 64'd10);
        foreach (hs_q[i]) check("held_result", 64'(hs_q[i]), 64'(i*16 + 8));

        // Random network with clamping in both directions.
        for (int i = 0; i < 512; i++) img_mem[i] = 10'($urandom % 1024);
        for (int i = 0; i < 1024; i++) w1_mem[i] = 16'(int'($urandom_range(0, 60)) - 30);
        for (int i = 0; i < 32; i++) b1_mem[i] = 16'(int'($urandom_range(0, 40000)) - 20000);
        for (int i = 0; i < 256; i++) w2_mem[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) b2_mem[i] = 16'($urandom);
        do_run(2, 10, lat, gd);
        check("random_done", 64'(gd), 64'd1);
        check("random_result_count", 64'(hs_q.size()), 64'd10);

        // Reset in row 2 L1; the next run restarts at row 0.
        do_run(3, 10, lat, gd);
        check("abort_no_done", 64'(gd), 64'd0);
        do_run(0, 1, lat, gd);
        check("restart_latency", 64'(lat), 64'd1231);
        check("restart_result_count", 64'(hs_q.size()), 64'd1);
        foreach (hs_q[i]) check("restart_row", 64'(hs_q[i] / 16), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mlp_sequencer.md
MLP_SEQUENCER -- requirements
Module: mlp_sequencer

Interface
REQ-001 SHALL have parameters: N_ROW=10 (image rows per run), N_IN=50 (pixels per row), N_HID=20 (hidden neurons), N_OUT=10 (classes), ACC_W=40 (accumulator width).
REQ-002 SHALL have ports clk (in, 1), one clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n (in, 1); reset is synchronous and active-low.
REQ-004 SHALL have ports start (in, 1) and busy (out, 1): run request and run-in-progress flag.
REQ-005 SHALL have ports img_addr (out, 9) = row*50+k, and img_data (in, 10, unsigned pixel).
REQ-006 SHALL have ports w1_addr (out, 10) = j*50+k, w1_data (in, 16, signed), b1_addr (out, 5) = j, and b1_data (in, 16, signed).
REQ-007 SHALL have ports w2_addr (out, 8) = o*20+j, w2_data (in, 16, signed), b2_addr (out, 4) = o, and b2_data (in, 16, signed).
REQ-008 SHALL have ports class_valid (out, 1), class_ready (in, 1), class_idx (out, 4) and class_row (out, 4): per-row result handshake.
REQ-009 SHALL have port done (out, 1): one-cycle pulse at the end of a run.

Function
REQ-010 SHALL treat all memory reads as synchronous with 1-cycle latency: an address driven in cycle t returns data in cycle t+1.
REQ-011 SHALL implement states IDLE, L1, L2, EMIT.
- IDLE -> L1 when start=1; row counter set to 0.
- start is ignored in every state except IDLE.
REQ-012 L1: for each j = 0..19, SHALL run 51 cycles.
- Cycles 0..49 issue k = 0..49.
- Cycle 50 drains.
- acc is loaded with sign-extended b1 plus the first product, then accumulates img_data*w1_data (signed, ACC_W bits, no saturation).
REQ-013 At each L1 drain, hidden[j] SHALL be written as: 0 if acc <= 0, 65535 if acc > 65535, else acc[15:0] (ReLU plus clamp to 16-bit unsigned); L1 lasts 1020 cycles.
REQ-014 L2: for each o = 0..9, SHALL run 21 cycles (20 issue cycles with j = 0..19, 1 drain).
- acc = b2 + sum of hidden[j]*w2_data, with hidden zero-extended.
- L2 lasts 210 cycles.
REQ-015 SHALL compute argmax incrementally at each L2 drain.
- o=0 always loads best.
- Later scores replace best only if strictly greater (signed), so ties keep the lowest index.
REQ-016 SHALL enter EMIT after the last L2 drain, with class_valid=1, class_idx=best index and class_row=row counter.
- class_valid first rises 1231 cycles after the edge that sampled start.
REQ-017 In EMIT, class_valid, class_idx and class_row SHALL stay stable until class_ready=1.
- Nothing else progresses while waiting.
- class_ready already high on the first EMIT cycle completes the handshake at that edge.
REQ-018 On handshake with row < 9, SHALL increment the row and enter L1 on the next cycle.
REQ-019 On handshake with row = 9, SHALL return to IDLE and pulse done for exactly one cycle.
REQ-020 busy SHALL be 1 in L1, L2 and EMIT, and 0 in IDLE.
REQ-021 Address outputs SHALL be 0 whenever not issuing; in L1, w2_addr and b2_addr SHALL be 0, and in L2, img_addr, w1_addr and b1_addr SHALL be 0.
REQ-022 Hidden storage SHALL be internal, 20x16 bits, written only in L1 and read only in L2.

Reset
REQ-023 When rst_n=0 at a clock edge, the block SHALL enter IDLE, from any state including mid-L1, mid-L2 or EMIT.
REQ-024 Reset SHALL set busy, done, class_valid, class_idx, class_row, all addresses, acc, best and the row counter to 0.
REQ-025 Reset need not clear the hidden buffer; its contents SHALL never affect outputs before being rewritten.
REQ-026 An aborted run SHALL be discarded; the next start SHALL begin at row 0.

Verification
REQ-027 Test: all w1/w2 = 0, b2 = {0,0,0,5,0,0,0,0,0,0}, class_ready tied 1 -> ten results, class_idx = 3, class_row = 0..9 in order, then one done pulse; first class_valid at cycle 1231 after start.
REQ-028 Test: b2 all equal to 7, all weights 0 -> class_idx = 0 for every row (tie rule).
REQ-029 Test: all pixels 1023, w1 = -1, b1 = 0, w2 = 100 for o=8 and 0 otherwise, b2 = 0 -> hidden = 0 (ReLU), all scores 0, class_idx = 0.
- Then b1 = 1000 -> hidden = 1000-51150 < 0, still class 0.
- Then w1 = +1, b1 = 0 -> hidden = 51150, class_idx = 8.
REQ-030 Test: class_ready held 0 for 100 cycles in EMIT -> class_valid, class_idx and class_row stable, all addresses 0, no row advance; raise class_ready -> next row L1 starts the following cycle.
REQ-031 Test: rst_n low for one cycle at cycle 500 of row 2's L1 -> all outputs 0, IDLE; next start produces class_row = 0 first.
REQ-032 Test: start pulsed during L2 and during EMIT -> no effect, row sequence and latency unchanged.
